// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: scans the attribute store on hblank and commits a
// priority-ordered active list. Optional overflow pulse: SPRITE_SCHED_OVERFLOW_IRQ_EN.
module sprite_line_scheduler #(
  parameter int unsigned MAX_SPRITES = 8,
  parameter int unsigned SLOTS       = 4,
  parameter int unsigned IDW         = $clog2(MAX_SPRITES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hblank_start,
  input  logic                  vsync_start,
  input  logic [9:0]            next_y,
  output logic [IDW-1:0]        attr_addr,
  input  logic [9:0]            attr_y,
  input  logic [3:0]            attr_h,
  input  logic                  attr_en,
  output logic                  busy,
  output logic                  list_ready,
  output logic [SLOTS-1:0]      slot_valid,
  output logic [SLOTS*IDW-1:0]  slot_id,
  output logic [SLOTS*4-1:0]    slot_row,
  output logic                  overflow,
  output logic                  overflow_irq
);

  localparam int unsigned CW = $clog2(SLOTS + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, COMMIT} state_t;

  state_t          state;
  state_t          state_next;
  logic            start;
  logic            eval_valid;
  logic [IDW-1:0]  eval_idx;
  logic [9:0]      line_y;
  logic [9:0]      diff;
  logic            hit;
  logic            full;
  logic            ovf_hit;
  logic [CW-1:0]   work_count;
  logic [IDW-1:0]  work_id  [SLOTS];
  logic [3:0]      work_row [SLOTS];

  // Next-state and hit evaluation; vsync overrides everything except a coincident hblank
  always_comb begin
    state_next = state;
    start      = 1'b0;
    diff       = line_y - attr_y;
    hit        = 1'b0;
    full       = (work_count == CW'(SLOTS));
    ovf_hit    = 1'b0;
    case (state)
      IDLE:   if (hblank_start) state_next = SCAN;
      SCAN:   if (attr_addr == IDW'(MAX_SPRITES - 1)) state_next = DRAIN;
      DRAIN:  state_next = COMMIT;
      COMMIT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (vsync_start) state_next = hblank_start ? SCAN : IDLE;
    start = hblank_start && ((state == IDLE) || vsync_start);
    if (eval_valid && !vsync_start && attr_en && (diff <= {6'b0, attr_h})) hit = 1'b1;
    ovf_hit = hit && full;
  end

  // State, scan counter, working list and committed outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      attr_addr  <= '0;
      busy       <= 1'b0;
      list_ready <= 1'b0;
      eval_valid <= 1'b0;
      eval_idx   <= '0;
      line_y     <= '0;
      work_count <= '0;
      slot_valid <= '0;
      slot_id    <= '0;
      slot_row   <= '0;
      overflow   <= 1'b0;
      for (int s = 0; s < int'(SLOTS); s++) begin
        work_id[s]  <= '0;
        work_row[s] <= '0;
      end
    end else begin
      state      <= state_next;
      busy       <= (state_next != IDLE);
      list_ready <= 1'b0;
      eval_valid <= (state == SCAN) && !vsync_start;
      eval_idx   <= attr_addr;

      if (start) begin
        attr_addr  <= '0;
        line_y     <= next_y;
        work_count <= '0;
        for (int s = 0; s < int'(SLOTS); s++) begin
          work_id[s]  <= '0;
          work_row[s] <= '0;
        end
      end else begin
        if (state == SCAN) attr_addr <= attr_addr + IDW'(1);
        if (hit && !full) begin
          for (int s = 0; s < int'(SLOTS); s++) begin
            if (CW'(s) == work_count) begin
              work_id[s]  <= eval_idx;
              work_row[s] <= diff[3:0];
            end
          end
          work_count <= work_count + CW'(1);
        end
      end

      if (ovf_hit) overflow <= 1'b1;

      if (state == COMMIT && !vsync_start) begin
        list_ready <= 1'b1;
        for (int s = 0; s < int'(SLOTS); s++) begin
          slot_valid[s]          <= (CW'(s) < work_count);
          slot_id[s*IDW +: IDW]  <= work_id[s];
          slot_row[s*4 +: 4]     <= work_row[s];
        end
      end

      if (vsync_start) begin
        overflow   <= 1'b0;
        slot_valid <= '0;
      end
    end
  end

`ifdef SPRITE_SCHED_OVERFLOW_IRQ_EN
  // Pulse only on the first dropped sprite of a frame
  always_ff @(posedge clk) begin
    if (reset) overflow_irq <= 1'b0;
    else       overflow_irq <= ovf_hit && !overflow;
  end
`else
  assign overflow_irq = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Bench for sprite_line_scheduler: directed vector table, corner sequences, and
// randomized lines checked against an arithmetic model of the selection rules.
module tb_sprite_line_scheduler;

`ifdef SPRITE_SCHED_OVERFLOW_IRQ_EN
  localparam int IRQ_EN = 1;
`else
  localparam int IRQ_EN = 0;
`endif

  logic        clk;
  logic        reset;
  logic        hblank_start;
  logic        vsync_start;
  logic [9:0]  next_y;
  logic [2:0]  attr_addr;
  logic [9:0]  attr_y;
  logic [3:0]  attr_h;
  logic        attr_en;
  logic        busy;
  logic        list_ready;
  logic [3:0]  slot_valid;
  logic [11:0] slot_id;
  logic [15:0] slot_row;
  logic        overflow;
  logic        overflow_irq;

  sprite_line_scheduler #(.MAX_SPRITES(8), .SLOTS(4), .IDW(3)) dut (
    .clk(clk), .reset(reset), .hblank_start(hblank_start), .vsync_start(vsync_start),
    .next_y(next_y), .attr_addr(attr_addr), .attr_y(attr_y), .attr_h(attr_h),
    .attr_en(attr_en), .busy(busy), .list_ready(list_ready), .slot_valid(slot_valid),
    .slot_id(slot_id), .slot_row(slot_row), .overflow(overflow), .overflow_irq(overflow_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attribute store with one-cycle registered read
  logic [9:0] mem_y  [8];
  logic [3:0] mem_h  [8];
  logic       mem_en [8];
  always @(posedge clk) begin
    attr_y  <= mem_y[attr_addr];
    attr_h  <= mem_h[attr_addr];
    attr_en <= mem_en[attr_addr];
  end

  typedef struct packed {
    logic            vs;
    logic [9:0]      ny;
    logic [7:0]      en;
    logic [7:0][9:0] y;
    logic [7:0][3:0] h;
    logic [3:0]      ev;
    logic [3:0][2:0] eid;
    logic [3:0][3:0] erow;
    logic            eovf;
    logic            eirq;
  } vec_t;

  vec_t tbl [7];
  int   tests;
  int   fails;
  int   lat, lr_cnt, irq_cnt;
  logic addr_ok, busy_ok;
  logic model_ovf;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic spr(input int v, input int i, input int y, input int h, input logic en);
    tbl[v].y[i]  = 10'(y);
    tbl[v].h[i]  = 4'(h);
    tbl[v].en[i] = en;
  endtask

  function automatic void model(input logic [9:0] ny, output logic [3:0] v,
                                output logic [3:0][2:0] id, output logic [3:0][3:0] row,
                                output int hits);
    v = '0; id = '0; row = '0; hits = 0;
    for (int i = 0; i < 8; i++) begin
      int d;
      d = (int'(ny) - int'(mem_y[i]) + 1024) % 1024;
      if (mem_en[i] && d <= int'(mem_h[i])) begin
        if (hits < 4) begin
          v[hits]   = 1'b1;
          id[hits]  = 3'(i);
          row[hits] = 4'(d);
        end
        hits++;
      end
    end
  endfunction

  task automatic pulse_vsync();
    @(negedge clk); vsync_start = 1'b1;
    @(negedge clk); vsync_start = 1'b0;
    model_ovf = 1'b0;
  endtask

  // Start a line at E0 and observe 21 cycles; optional extra hblank sampled at edge extra_at
  task automatic run_line(input logic [9:0] ny, input int extra_at);
    @(negedge clk); next_y = ny; hblank_start = 1'b1;
    @(negedge clk); hblank_start = 1'b0;
    lat = -1; lr_cnt = 0; irq_cnt = 0; addr_ok = 1'b1; busy_ok = 1'b1;
    for (int n = 0; n <= 20; n++) begin
      if (n < 8 && attr_addr != 3'(n)) addr_ok = 1'b0;
      if (n < 10 && !busy) busy_ok = 1'b0;
      if (n == 10 && busy) busy_ok = 1'b0;
      if (list_ready) begin lr_cnt++; if (lat < 0) lat = n; end
      if (overflow_irq) irq_cnt++;
      hblank_start = (n + 1 == extra_at);
      @(negedge clk);
    end
    hblank_start = 1'b0;
  endtask

  task automatic check_line(input logic [3:0] ev, input logic [3:0][2:0] eid,
                            input logic [3:0][3:0] erow, input logic eovf, input int eirq);
    logic [3:0][2:0] gid, xid;
    logic [3:0][3:0] grow, xrow;
    gid = '0; xid = '0; grow = '0; xrow = '0;
    for (int s = 0; s < 4; s++) begin
      if (ev[s]) begin
        gid[s] = slot_id[s*3 +: 3];   xid[s] = eid[s];
        grow[s] = slot_row[s*4 +: 4]; xrow[s] = erow[s];
      end
    end
    chk("list_ready latency", 32'(lat), 32'd10);
    chk("list_ready count", 32'(lr_cnt), 32'd1);
    chk("attr_addr sequence", 32'(addr_ok), 32'd1);
    chk("busy window", 32'(busy_ok), 32'd1);
    chk("slot_valid", 32'(slot_valid), 32'(ev));
    chk("slot_id", 32'(gid), 32'(xid));
    chk("slot_row", 32'(grow), 32'(xrow));
    chk("overflow", 32'(overflow), 32'(eovf));
    chk("overflow_irq pulses", 32'(irq_cnt), 32'(eirq));
  endtask

  task automatic load_vec(input int v);
    for (int i = 0; i < 8; i++) begin
      mem_y[i] = tbl[v].y[i]; mem_h[i] = tbl[v].h[i]; mem_en[i] = tbl[v].en[i];
    end
  endtask

  initial begin
    logic            ok;
    logic [3:0]      ev;
    logic [3:0][2:0] eid;
    logic [3:0][3:0] erow;
    int              hits;
    tests = 0; fails = 0; model_ovf = 1'b0;
    reset = 1'b1; hblank_start = 1'b0; vsync_start = 1'b0; next_y = '0;
    for (int i = 0; i < 8; i++) begin mem_y[i] = '0; mem_h[i] = '0; mem_en[i] = 1'b0; end

    for (int v = 0; v < 7; v++) tbl[v] = '0;
    tbl[0].vs = 1'b1; tbl[0].ny = 10'd100;
    spr(0, 2, 95, 15, 1'b1); spr(0, 5, 100, 0, 1'b1);
    tbl[0].ev = 4'b0011; tbl[0].eid[0] = 3'd2; tbl[0].erow[0] = 4'd5;
    tbl[0].eid[1] = 3'd5; tbl[0].erow[1] = 4'd0;
    tbl[1].vs = 1'b1; tbl[1].ny = 10'd53;
    for (int i = 0; i < 6; i++) spr(1, i, 50, 7, 1'b1);
    tbl[1].ev = 4'b1111; tbl[1].eovf = 1'b1; tbl[1].eirq = 1'(IRQ_EN);
    for (int s = 0; s < 4; s++) begin tbl[1].eid[s] = 3'(s); tbl[1].erow[s] = 4'd3; end
    tbl[2] = tbl[1]; tbl[2].vs = 1'b0; tbl[2].eirq = 1'b0;
    tbl[3].vs = 1'b1; tbl[3].ny = 10'd3; spr(3, 0, 1020, 15, 1'b1);
    tbl[3].ev = 4'b0001; tbl[3].eid[0] = 3'd0; tbl[3].erow[0] = 4'd7;
    tbl[4] = tbl[3]; tbl[4].vs = 1'b0; tbl[4].ny = 10'd12; tbl[4].ev = 4'b0000;
    tbl[5].vs = 1'b1; tbl[5].ny = 10'd204;
    spr(5, 3, 204, 0, 1'b0); spr(5, 6, 199, 4, 1'b1); spr(5, 7, 200, 4, 1'b1);
    spr(5, 1, 205, 3, 1'b1);
    tbl[5].ev = 4'b0001; tbl[5].eid[0] = 3'd7; tbl[5].erow[0] = 4'd4;
    tbl[6].ny = 10'd204;
    spr(6, 0, 204, 0, 1'b1); spr(6, 1, 190, 15, 1'b1); spr(6, 2, 188, 15, 1'b1);
    tbl[6].ev = 4'b0011; tbl[6].eid[1] = 3'd1; tbl[6].erow[1] = 4'd14;

    // Reset state, then 20 idle cycles
    repeat (3) @(negedge clk);
    chk("reset outputs", 32'({attr_addr, busy, list_ready, slot_valid, slot_id, slot_row,
                               overflow, overflow_irq}), 32'd0);
    reset = 1'b0;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if ({attr_addr, busy, list_ready, slot_valid, slot_id, slot_row, overflow,
           overflow_irq} != '0) ok = 1'b0;
    end
    chk("idle after reset", 32'(ok), 32'd1);

    for (int v = 0; v < 7; v++) begin
      if (tbl[v].vs) pulse_vsync();
      load_vec(v);
      run_line(tbl[v].ny, 0);
      check_line(tbl[v].ev, tbl[v].eid, tbl[v].erow, tbl[v].eovf, int'(tbl[v].eirq));
    end

    // vsync sampled at the fourth edge of a scan aborts it
    pulse_vsync(); load_vec(1); run_line(10'd53, 0);
    @(negedge clk); hblank_start = 1'b1;
    @(negedge clk); hblank_start = 1'b0;
    repeat (3) @(negedge clk);
    vsync_start = 1'b1;
    @(negedge clk); vsync_start = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort slot_valid", 32'(slot_valid), 32'd0);
    chk("abort overflow", 32'(overflow), 32'd0);
    lr_cnt = 0;
    repeat (15) begin @(negedge clk); if (list_ready) lr_cnt++; end
    chk("abort no list_ready", 32'(lr_cnt), 32'd0);

    // Second hblank during a scan is ignored
    load_vec(0); run_line(10'd100, 3);
    check_line(4'b0011, tbl[0].eid, tbl[0].erow, 1'b0, 0);

    // Reset mid-scan
    @(negedge clk); hblank_start = 1'b1;
    @(negedge clk); hblank_start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("reset mid-scan busy", 32'(busy), 32'd0);
    chk("reset mid-scan slot_valid", 32'(slot_valid), 32'd0);
    lr_cnt = 0;
    repeat (15) begin @(negedge clk); if (list_ready) lr_cnt++; end
    chk("reset mid-scan no list_ready", 32'(lr_cnt), 32'd0);

    // Randomized lines against the model
    pulse_vsync();
    for (int it = 0; it < 40; it++) begin
      logic [9:0] ny;
      int         eirq;
      if ($urandom_range(0, 3) == 0) pulse_vsync();
      ny = 10'($urandom);
      for (int i = 0; i < 8; i++) begin
        mem_en[i] = ($urandom_range(0, 3) != 0);
        mem_h[i]  = 4'($urandom);
        mem_y[i]  = 10'((int'(ny) - int'($urandom_range(0, 20)) + 1024) % 1024);
      end
      model(ny, ev, eid, erow, hits);
      eirq = 0;
      if (hits > 4) begin
        if (!model_ovf) eirq = IRQ_EN;
        model_ovf = 1'b1;
      end
      run_line(ny, 0);
      check_line(ev, eid, erow, model_ovf, eirq);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
